// File: rtl/anabellek_pkg.sv
// rtl/anabellek_pkg.sv - shared FSM state type and geometry constants for the main-memory model
package anabellek_pkg;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISLEM = 2'd1,
        CEVAP = 2'd2
    } durum_e;

    localparam int BLOK_BOYUTU_VARSAYILAN = 128;
    localparam int OFSET_BIT              = 4;

endpackage

// File: rtl/anabellek_dizi.sv
// rtl/anabellek_dizi.sv - line storage: one synchronous write port, one asynchronous read port
module anabellek_dizi #(
    parameter int SATIR_BIT   = 10,
    parameter int BLOK_BOYUTU = 128
) (
    input  logic                   clk_i,
    input  logic                   yaz_en_i,
    input  logic [SATIR_BIT-1:0]   yaz_adres_i,
    input  logic [BLOK_BOYUTU-1:0] yaz_veri_i,
    input  logic [SATIR_BIT-1:0]   oku_adres_i,
    output logic [BLOK_BOYUTU-1:0] oku_veri_o
);

    // Deliberately not reset: contents survive a reset of the controller.
    logic [BLOK_BOYUTU-1:0] hucre_q [2**SATIR_BIT];

    always_ff @(posedge clk_i) begin
        if (yaz_en_i) begin
            hucre_q[yaz_adres_i] <= yaz_veri_i;
        end
    end

    assign oku_veri_o = hucre_q[oku_adres_i];

endmodule

// File: rtl/anabellek.sv
// rtl/anabellek.sv - fixed-latency main-memory endpoint; ANABELLEK_ISTATISTIK_EN adds read/write counters
module anabellek
    import anabellek_pkg::*;
#(
    parameter int BLOK_BOYUTU = BLOK_BOYUTU_VARSAYILAN,
    parameter int SATIR_BIT   = 10,
    parameter int GECIKME     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [31:0]            istek_adres_i,
    input  logic [BLOK_BOYUTU-1:0] istek_veri_i,
    input  logic                   istek_gecerli_i,
    input  logic                   istek_yaz_i,
    output logic                   istek_hazir_o,
    output logic [BLOK_BOYUTU-1:0] cevap_veri_o,
    output logic                   cevap_gecerli_o,
`ifdef ANABELLEK_ISTATISTIK_EN
    output logic [31:0]            okuma_sayisi_o,
    output logic [31:0]            yazma_sayisi_o,
`endif
    input  logic                   cevap_hazir_i
);

    localparam logic [7:0] GECIKME_YUKLE = 8'(GECIKME - 1);

    durum_e                 durum_q, durum_d;
    logic [7:0]             sayac_q, sayac_d;
    logic [SATIR_BIT-1:0]   adres_q, adres_d;
    logic                   yaz_q, yaz_d;
    logic [BLOK_BOYUTU-1:0] veri_q, veri_d;
    logic                   gecerli_q, gecerli_d;
    logic                   dizi_yaz_en;
    logic                   kabul;
    logic [SATIR_BIT-1:0]   istek_satir;
    logic [BLOK_BOYUTU-1:0] dizi_oku_veri;
    logic                   unused_adres_bitleri;

    assign istek_satir          = istek_adres_i[OFSET_BIT+SATIR_BIT-1:OFSET_BIT];
    assign unused_adres_bitleri = ^{istek_adres_i[31:OFSET_BIT+SATIR_BIT], istek_adres_i[OFSET_BIT-1:0]};
    assign istek_hazir_o        = (durum_q == BOSTA);
    assign kabul                = istek_hazir_o && istek_gecerli_i;

    always_comb begin
        durum_d     = durum_q;
        sayac_d     = sayac_q;
        adres_d     = adres_q;
        yaz_d       = yaz_q;
        veri_d      = veri_q;
        gecerli_d   = gecerli_q;
        dizi_yaz_en = 1'b0;
        case (durum_q)
            BOSTA: begin
                if (istek_gecerli_i) begin
                    adres_d     = istek_satir;
                    yaz_d       = istek_yaz_i;
                    sayac_d     = GECIKME_YUKLE;
                    durum_d     = ISLEM;
                    // Writes land immediately so a following read sees them.
                    dizi_yaz_en = istek_yaz_i;
                end
            end
            ISLEM: begin
                if (sayac_q == 8'd0) begin
                    if (yaz_q) begin
                        durum_d = BOSTA;
                    end else begin
                        veri_d    = dizi_oku_veri;
                        gecerli_d = 1'b1;
                        durum_d   = CEVAP;
                    end
                end else begin
                    sayac_d = sayac_q - 8'd1;
                end
            end
            CEVAP: begin
                if (cevap_hazir_i) begin
                    gecerli_d = 1'b0;
                    durum_d   = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q   <= BOSTA;
            sayac_q   <= 8'd0;
            adres_q   <= '0;
            yaz_q     <= 1'b0;
            veri_q    <= '0;
            gecerli_q <= 1'b0;
        end else begin
            durum_q   <= durum_d;
            sayac_q   <= sayac_d;
            adres_q   <= adres_d;
            yaz_q     <= yaz_d;
            veri_q    <= veri_d;
            gecerli_q <= gecerli_d;
        end
    end

    assign cevap_veri_o    = veri_q;
    assign cevap_gecerli_o = gecerli_q;

    anabellek_dizi #(
        .SATIR_BIT   (SATIR_BIT),
        .BLOK_BOYUTU (BLOK_BOYUTU)
    ) u_dizi (
        .clk_i       (clk_i),
        .yaz_en_i    (dizi_yaz_en),
        .yaz_adres_i (istek_satir),
        .yaz_veri_i  (istek_veri_i),
        .oku_adres_i (adres_q),
        .oku_veri_o  (dizi_oku_veri)
    );

`ifdef ANABELLEK_ISTATISTIK_EN
    logic [31:0] okuma_q, okuma_d;
    logic [31:0] yazma_q, yazma_d;

    always_comb begin
        okuma_d = okuma_q;
        yazma_d = yazma_q;
        if (kabul && !istek_yaz_i) okuma_d = okuma_q + 32'd1;
        if (kabul &&  istek_yaz_i) yazma_d = yazma_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            okuma_q <= 32'd0;
            yazma_q <= 32'd0;
        end else begin
            okuma_q <= okuma_d;
            yazma_q <= yazma_d;
        end
    end

    assign okuma_sayisi_o = okuma_q;
    assign yazma_sayisi_o = yazma_q;
`else
    logic unused_kabul;
    assign unused_kabul = kabul;
`endif

endmodule
